serial_link: RTL and testbench

SERIAL_LINK -- requirements
Module: serial_link

---
 rtl/serial_pkg.sv | 14 +
 rtl/serial_bit_timer.sv | 23 ++
 rtl/serial_link.sv | 185 ++++++++++++++++++
 tb/tb_serial_link.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared frame constants and FSM state encodings for the serial_link UART.
package serial_pkg;
   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;
   localparam int unsigned BIT_CNT_W = 3;

   typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

   localparam bit_cnt_t LAST_DATA = bit_cnt_t'(DATA_BITS - 1);
   localparam bit_cnt_t LAST_STOP = bit_cnt_t'(STOP_BITS - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
endpackage

// File: rtl/serial_bit_timer.sv
// Down-counting bit-period timer: load a count, done while it sits at zero.
module serial_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 5859
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            load,
   input  logic [$clog2(CLKS_PER_BIT)-1:0] load_val,
   output logic                            done
);
   logic [$clog2(CLKS_PER_BIT)-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign done = (count == '0);
endmodule

// File: rtl/serial_link.sv
// Full-duplex 8N1 UART: independent RX and TX state machines on one clock.
module serial_link
   import serial_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 5859
) (
   input  logic       eclk,
   input  logic       ereset_n,
   input  logic       rxd,
   output logic       txd,
   output logic [7:0] rx_data,
   output logic       rx_flag,
   input  logic       rx_ack,
   input  logic [7:0] tx_data,
   output logic       tx_flag,
   input  logic       tx_wr,
   output logic       rx_err
);
   localparam int unsigned TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2);

   logic [1:0] sync;
   logic       rx_sync;

   rx_state_t            rx_state, rx_state_n;
   logic [DATA_BITS-1:0] rx_shift, rx_shift_n, rx_data_n;
   bit_cnt_t             rx_bit, rx_bit_n;
   logic                 rx_flag_n, rx_err_n, rx_armed, rx_armed_n;
   logic                 rx_load, rx_done;
   logic [TW-1:0]        rx_load_val;

   tx_state_t            tx_state, tx_state_n;
   logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
   bit_cnt_t             tx_bit, tx_bit_n;
   logic                 txd_n, tx_flag_n, tx_load, tx_done;

   always_ff @(posedge eclk or negedge ereset_n) begin
      if (!ereset_n) sync <= '1;
      else           sync <= {sync[0], rxd};
   end
   assign rx_sync = sync[1];

   serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
      .clk(eclk), .rst_n(ereset_n), .load(rx_load), .load_val(rx_load_val), .done(rx_done)
   );

   serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
      .clk(eclk), .rst_n(ereset_n), .load(tx_load), .load_val(FULL), .done(tx_done)
   );

   always_ff @(posedge eclk or negedge ereset_n) begin
      if (!ereset_n) begin
         rx_state <= RX_IDLE;
         rx_shift <= '0;
         rx_bit   <= '0;
         rx_data  <= '0;
         rx_flag  <= 1'b0;
         rx_err   <= 1'b0;
         rx_armed <= 1'b1;
      end else begin
         rx_state <= rx_state_n;
         rx_shift <= rx_shift_n;
         rx_bit   <= rx_bit_n;
         rx_data  <= rx_data_n;
         rx_flag  <= rx_flag_n;
         rx_err   <= rx_err_n;
         rx_armed <= rx_armed_n;
      end
   end

   always_comb begin
      rx_state_n  = rx_state;
      rx_shift_n  = rx_shift;
      rx_bit_n    = rx_bit;
      rx_data_n   = rx_data;
      rx_flag_n   = rx_flag;
      rx_err_n    = rx_err;
      rx_armed_n  = rx_armed;
      rx_load     = 1'b0;
      rx_load_val = FULL;
      // ack clears first so a completion in the same cycle overrides it
      if (rx_ack) rx_flag_n = 1'b0;
      unique case (rx_state)
         RX_IDLE: begin
            if (!rx_armed) begin
               if (rx_sync) rx_armed_n = 1'b1;
            end else if (!rx_sync) begin
               rx_state_n  = RX_START;
               rx_load     = 1'b1;
               rx_load_val = HALF;
            end
         end
         RX_START: if (rx_done) begin
            if (!rx_sync) begin
               rx_state_n = RX_DATA;
               rx_bit_n   = '0;
               rx_load    = 1'b1;
            end else begin
               rx_state_n = RX_IDLE;
            end
         end
         RX_DATA: if (rx_done) begin
            rx_shift_n = {rx_sync, rx_shift[DATA_BITS-1:1]};
            rx_load    = 1'b1;
            if (rx_bit == LAST_DATA) rx_state_n = RX_STOP;
            else                     rx_bit_n   = rx_bit + 1'b1;
         end
         RX_STOP: if (rx_done) begin
            rx_state_n = RX_IDLE;
            if (rx_sync) begin
               rx_data_n = rx_shift;
               rx_flag_n = 1'b1;
               if (rx_flag) rx_err_n = 1'b1;
            end else begin
               rx_err_n   = 1'b1;
               rx_armed_n = 1'b0;
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge eclk or negedge ereset_n) begin
      if (!ereset_n) begin
         tx_state <= TX_IDLE;
         tx_shift <= '0;
         tx_bit   <= '0;
         txd      <= 1'b1;
         tx_flag  <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_shift <= tx_shift_n;
         tx_bit   <= tx_bit_n;
         txd      <= txd_n;
         tx_flag  <= tx_flag_n;
      end
   end

   always_comb begin
      tx_state_n = tx_state;
      tx_shift_n = tx_shift;
      tx_bit_n   = tx_bit;
      txd_n      = txd;
      tx_flag_n  = tx_flag;
      tx_load    = 1'b0;
      unique case (tx_state)
         TX_IDLE: if (tx_wr) begin
            tx_state_n = TX_START;
            tx_shift_n = tx_data;
            tx_bit_n   = '0;
            txd_n      = 1'b0;
            tx_flag_n  = 1'b0;
            tx_load    = 1'b1;
         end
         TX_START: if (tx_done) begin
            tx_state_n = TX_DATA;
            txd_n      = tx_shift[0];
            tx_load    = 1'b1;
         end
         TX_DATA: if (tx_done) begin
            tx_load = 1'b1;
            if (tx_bit == LAST_DATA) begin
               tx_state_n = TX_STOP;
               tx_bit_n   = '0;
               txd_n      = 1'b1;
            end else begin
               tx_bit_n   = tx_bit + 1'b1;
               tx_shift_n = tx_shift >> 1;
               txd_n      = tx_shift[1];
            end
         end
         TX_STOP: if (tx_done) begin
            if (tx_bit == LAST_STOP) begin
               tx_state_n = TX_IDLE;
               tx_flag_n  = 1'b1;
            end else begin
               tx_bit_n = tx_bit + 1'b1;
               tx_load  = 1'b1;
            end
         end
         default: tx_state_n = TX_IDLE;
      endcase
   end
endmodule

// File: tb/tb_serial_link.sv
// Scoreboard bench for serial_link at 16 clocks per bit.
module tb_serial_link;
   localparam int unsigned CPB = 16;

   logic       eclk = 1'b0;
   logic       ereset_n = 1'b1;
   logic       rxd = 1'b1;
   logic       txd;
   logic [7:0] rx_data;
   logic       rx_flag;
   logic       rx_ack = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_flag;
   logic       tx_wr = 1'b0;
   logic       rx_err;

   int passed = 0;
   int total  = 0;
   logic       exp_bits[$];
   logic [7:0] exp_rx[$];

   serial_link #(.CLKS_PER_BIT(CPB)) dut (
      .eclk(eclk), .ereset_n(ereset_n), .rxd(rxd), .txd(txd),
      .rx_data(rx_data), .rx_flag(rx_flag), .rx_ack(rx_ack),
      .tx_data(tx_data), .tx_flag(tx_flag), .tx_wr(tx_wr), .rx_err(rx_err)
   );

   always #5 eclk = ~eclk;

   task automatic do_reset();
      @(negedge eclk);
      ereset_n = 1'b0;
      repeat (3) @(negedge eclk);
      ereset_n = 1'b1;
      repeat (3) @(negedge eclk);
   endtask

   // preloaded: tx_wr already raised at the previous negedge by a chained call
   task automatic tx_frame(input logic [7:0] b, input bit busy_wr, input bit preloaded,
                           input bit chain, input logic [7:0] nxt);
      int low_cnt;
      logic e;
      exp_bits.push_back(1'b0);
      for (int k = 0; k < 8; k++) exp_bits.push_back(b[k]);
      exp_bits.push_back(1'b1);
      if (!preloaded) begin
         @(negedge eclk);
         tx_data = b;
         tx_wr   = 1'b1;
      end
      @(negedge eclk);
      tx_wr   = 1'b0;
      tx_data = '0;
      low_cnt = 0;
      for (int i = 0; i < 170; i++) begin
         if (i == 0) begin
            total++;
            if (txd !== 1'b0) $display("FAIL tx_latency txd=%b expected 0", txd);
            else passed++;
         end
         if ((i % 16) == 8 && i < 160) begin
            e = exp_bits.pop_front();
            total++;
            if (txd !== e) $display("FAIL tx_bit%0d data=%02h txd=%b expected %b", i / 16, b, txd, e);
            else passed++;
         end
         if (tx_flag === 1'b0) low_cnt++;
         if (chain && i == 160) begin
            tx_data = nxt;
            tx_wr   = 1'b1;
            break;
         end
         if (busy_wr && i == 40) begin tx_data = 8'hFF; tx_wr = 1'b1; end
         if (busy_wr && i == 41) begin tx_data = 8'h00; tx_wr = 1'b0; end
         @(negedge eclk);
      end
      total++;
      if (low_cnt != 160) $display("FAIL tx_flag_low cycles=%0d expected 160", low_cnt);
      else passed++;
   endtask

   task automatic drive_rx(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (CPB) @(negedge eclk);
      for (int k = 0; k < 8; k++) begin
         rxd = b[k];
         repeat (CPB) @(negedge eclk);
      end
      rxd = stop;
      repeat (CPB) @(negedge eclk);
      rxd = 1'b1;
   endtask

   task automatic test_reset();
      #2 ereset_n = 1'b0;
      repeat (3) @(negedge eclk);
      total++;
      if (txd !== 1'b1) $display("FAIL reset_txd txd=%b expected 1", txd); else passed++;
      total++;
      if (tx_flag !== 1'b1) $display("FAIL reset_tx_flag got=%b expected 1", tx_flag); else passed++;
      total++;
      if (rx_flag !== 1'b0) $display("FAIL reset_rx_flag got=%b expected 0", rx_flag); else passed++;
      total++;
      if (rx_data !== 8'h00) $display("FAIL reset_rx_data got=%02h expected 00", rx_data); else passed++;
      total++;
      if (rx_err !== 1'b0) $display("FAIL reset_rx_err got=%b expected 0", rx_err); else passed++;
      ereset_n = 1'b1;
      repeat (3) @(negedge eclk);
   endtask

   task automatic test_tx();
      tx_frame(8'h41, 1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic check_rx_byte(input string name, input logic exp_err);
      logic [7:0] e;
      e = exp_rx.pop_front();
      total++;
      if (rx_flag !== 1'b1) $display("FAIL %s_flag got=%b expected 1", name, rx_flag); else passed++;
      total++;
      if (rx_data !== e) $display("FAIL %s_data got=%02h expected %02h", name, rx_data, e); else passed++;
      total++;
      if (rx_err !== exp_err) $display("FAIL %s_err got=%b expected %b", name, rx_err, exp_err); else passed++;
   endtask

   task automatic ack_rx(input string name);
      rx_ack = 1'b1;
      @(negedge eclk);
      rx_ack = 1'b0;
      total++;
      if (rx_flag !== 1'b0) $display("FAIL %s_ack got=%b expected 0", name, rx_flag); else passed++;
   endtask

   task automatic test_rx();
      exp_rx.push_back(8'hD5);
      drive_rx(8'hD5, 1'b1);
      check_rx_byte("rx_d5", 1'b0);
      repeat (4) @(negedge eclk);
      total++;
      if (rx_flag !== 1'b1) $display("FAIL rx_hold got=%b expected 1", rx_flag); else passed++;
      ack_rx("rx_d5");
   endtask

   task automatic test_glitch();
      rxd = 1'b0;
      repeat (5) @(negedge eclk);
      rxd = 1'b1;
      repeat (3 * CPB) @(negedge eclk);
      total++;
      if (rx_flag !== 1'b0) $display("FAIL glitch_flag got=%b expected 0", rx_flag); else passed++;
      total++;
      if (rx_err !== 1'b0) $display("FAIL glitch_err got=%b expected 0", rx_err); else passed++;
   endtask

   task automatic test_overrun();
      exp_rx.push_back(8'h11);
      drive_rx(8'h11, 1'b1);
      check_rx_byte("ovr_first", 1'b0);
      repeat (CPB) @(negedge eclk);
      exp_rx.push_back(8'h22);
      drive_rx(8'h22, 1'b1);
      check_rx_byte("ovr_second", 1'b1);
      ack_rx("ovr");
   endtask

   task automatic test_framing();
      drive_rx(8'h33, 1'b0);
      repeat (CPB) @(negedge eclk);
      total++;
      if (rx_flag !== 1'b0) $display("FAIL frame_flag got=%b expected 0", rx_flag); else passed++;
      total++;
      if (rx_err !== 1'b1) $display("FAIL frame_err got=%b expected 1", rx_err); else passed++;
      exp_rx.push_back(8'h5A);
      drive_rx(8'h5A, 1'b1);
      check_rx_byte("frame_recover", 1'b1);
      ack_rx("frame_recover");
   endtask

   task automatic test_reset_mid_tx();
      @(negedge eclk);
      tx_data = 8'h00;
      tx_wr   = 1'b1;
      @(negedge eclk);
      tx_wr   = 1'b0;
      repeat (4 * CPB + 8) @(negedge eclk);
      total++;
      if (txd !== 1'b0) $display("FAIL abort_pre txd=%b expected 0", txd); else passed++;
      ereset_n = 1'b0;
      #1;
      total++;
      if (txd !== 1'b1) $display("FAIL abort_txd txd=%b expected 1", txd); else passed++;
      total++;
      if (tx_flag !== 1'b1) $display("FAIL abort_tx_flag got=%b expected 1", tx_flag); else passed++;
      @(negedge eclk);
      ereset_n = 1'b1;
      repeat (3) @(negedge eclk);
      tx_frame(8'h55, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_back_to_back();
      tx_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8'h3C);
      tx_frame(8'h3C, 1'b0, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic test_full_duplex();
      fork
         tx_frame(8'h96, 1'b0, 1'b0, 1'b0, 8'h00);
         begin
            @(negedge eclk);
            exp_rx.push_back(8'h69);
            drive_rx(8'h69, 1'b1);
         end
      join
      check_rx_byte("duplex", 1'b0);
      ack_rx("duplex");
   endtask

   initial begin
      test_reset();
      test_tx();
      test_rx();
      test_glitch();
      test_overrun();
      do_reset();
      test_framing();
      test_reset_mid_tx();
      test_back_to_back();
      test_full_duplex();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout passed=%0d total=%0d", passed, total);
      $fatal(1, "timeout");
   end
endmodule
